// File: rtl/md_sched_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op encodings,
// default latencies, FSM state type.
package md_sched_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;
    localparam int unsigned CNT_W              = 5;

    function automatic logic is_arith(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mul(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/md_sched_if.sv
// E-stage MD request/response bundle between the pipeline and md_sched.
interface md_sched_if;
    import md_sched_pkg::*;

    logic        start;
    md_op_e      md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        md_D;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, md_op, src_a, src_b, md_D,
                    input  busy, stall_md, hi, lo);
    modport slave  (input  start, md_op, src_a, src_b, md_D,
                    output busy, stall_md, hi, lo);
endinterface

// File: rtl/md_sched_calc.sv
// Combinational 64-bit MULT/MULTU/DIV/DIVU result generator for md_sched.
module md_calc
    import md_sched_pkg::*;
(
    input  md_op_e      op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic [31:0] pending_hi,
    output logic [31:0] pending_lo,
    output logic        keep,
    output logic        trivial
);
    logic signed [63:0] sa, sb, sprod;
    logic        [63:0] uprod;
    logic        [31:0] divisor;
    logic signed [31:0] squo, srem;
    logic        [31:0] uquo, urem;
    logic               b_zero;

    // Divisor forced non-zero so divide-by-zero never produces X; keep masks the commit.
    assign b_zero  = (src_b == '0);
    assign divisor = b_zero ? 32'd1 : src_b;
    assign sa      = {{32{src_a[31]}}, src_a};
    assign sb      = {{32{src_b[31]}}, src_b};
    assign sprod   = sa * sb;
    assign uprod   = {32'd0, src_a} * {32'd0, src_b};
    assign squo    = $signed(src_a) / $signed(divisor);
    assign srem    = $signed(src_a) % $signed(divisor);
    assign uquo    = src_a / divisor;
    assign urem    = src_a % divisor;

    always_comb begin
        pending_hi = '0;
        pending_lo = '0;
        keep       = 1'b0;
        trivial    = 1'b0;
        case (op)
            MD_MULT: begin
                {pending_hi, pending_lo} = sprod;
                trivial = (src_a == '0) || b_zero;
            end
            MD_MULTU: begin
                {pending_hi, pending_lo} = uprod;
                trivial = (src_a == '0) || b_zero;
            end
            MD_DIV: begin
                pending_hi = srem;
                pending_lo = squo;
                keep       = b_zero;
                trivial    = b_zero;
            end
            MD_DIVU: begin
                pending_hi = urem;
                pending_lo = uquo;
                keep       = b_zero;
                trivial    = b_zero;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/md_sched.sv
// HI/LO multiply/divide sequencer: fixed busy window, commit at end, D-stage stall.
// Optional MD_EARLY_DONE_EN: zero-operand MULT/U and divide-by-zero finish after one busy cycle.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    md_sched_if.slave  md
);
    state_e           state, state_nx;
    logic [CNT_W-1:0] cnt, load_cnt;
    logic [31:0]      pending_hi, pending_lo, hi, lo;
    logic             pending_keep;
    logic [31:0]      calc_hi, calc_lo;
    logic             calc_keep, calc_trivial;
    logic             launch, last, busy, stall_md;

    md_calc u_calc (
        .op         (md.md_op),
        .src_a      (md.src_a),
        .src_b      (md.src_b),
        .pending_hi (calc_hi),
        .pending_lo (calc_lo),
        .keep       (calc_keep),
        .trivial    (calc_trivial)
    );

    assign launch = (state == IDLE) && md.start && is_arith(md.md_op);
    assign last   = (state == RUN) && (cnt == CNT_W'(1));

`ifdef MD_EARLY_DONE_EN
    assign load_cnt = calc_trivial ? CNT_W'(1)
                    : (is_mul(md.md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES));
`else
    assign load_cnt = is_mul(md.md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (launch) state_nx = RUN;
            RUN:     if (last)   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Reset gate keeps stall low while reset is held even if start/md_D float high.
    always_comb begin
        busy     = (state == RUN);
        stall_md = md.md_D && (md.start || busy) && reset;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt          <= '0;
            pending_hi   <= '0;
            pending_lo   <= '0;
            pending_keep <= 1'b0;
            hi           <= '0;
            lo           <= '0;
        end else if (state == IDLE) begin
            if (launch) begin
                cnt          <= load_cnt;
                pending_hi   <= calc_hi;
                pending_lo   <= calc_lo;
                pending_keep <= calc_keep;
            end else if (md.start && md.md_op == MD_MTHI) begin
                hi <= md.src_a;
            end else if (md.start && md.md_op == MD_MTLO) begin
                lo <= md.src_a;
            end
        end else begin
            cnt <= cnt - CNT_W'(1);
            if (last && !pending_keep) begin
                hi <= pending_hi;
                lo <= pending_lo;
            end
        end
    end

    assign md.busy     = busy;
    assign md.stall_md = stall_md;
    assign md.hi       = hi;
    assign md.lo       = lo;
endmodule

// File: tb/tb_md_sched.sv
// Directed scoreboard bench for md_sched: busy window length, HI/LO commit, stall, reset abort.
module tb_md_sched;
    import md_sched_pkg::*;

`ifdef MD_EARLY_DONE_EN
    localparam int unsigned ZMUL = 1;
    localparam int unsigned ZDIV = 1;
`else
    localparam int unsigned ZMUL = 5;
    localparam int unsigned ZDIV = 10;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_sched_if bus ();

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi, m_lo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic d, input int unsigned n,
                          input logic [31:0] eh, input logic [31:0] el, input logic inject);
        logic [63:0] e;
        int unsigned cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = op; bus.src_a = a; bus.src_b = b; bus.md_D = d;
        exp_q.push_back({eh, el});
        #1 check("stall_start", 64'(bus.stall_md), 64'(d));
        @(negedge clk);
        bus.start = 1'b0; bus.src_a = '0; bus.src_b = '0;
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < 64) begin
            bus.start = 1'b0;
            check("hold_hilo", {bus.hi, bus.lo}, {m_hi, m_lo});
            if (inject && cnt == 1) begin
                bus.start = 1'b1; bus.md_op = MD_MTLO; bus.src_a = 32'hDEADBEEF;
            end
            #1 check("stall_busy", 64'(bus.stall_md), 64'(d));
            cnt++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("busy_len", 64'(cnt), 64'(n));
        check("stall_after", 64'(bus.stall_md), 64'd0);
        bus.md_D = 1'b0;
        if (exp_q.size() == 0) begin
            check("queue_empty", 64'd0, 64'd1);
        end else begin
            e = exp_q.pop_front();
            check("hi", 64'(bus.hi), 64'(e[63:32]));
            check("lo", 64'(bus.lo), 64'(e[31:0]));
            m_hi = e[63:32];
            m_lo = e[31:0];
        end
    endtask

    task automatic run_mt(input md_op_e op, input logic [31:0] a, input logic d);
        logic [63:0] e;
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = op; bus.src_a = a; bus.md_D = d;
        exp_q.push_back(op == MD_MTHI ? {a, m_lo} : {m_hi, a});
        #1 check("mt_stall", 64'(bus.stall_md), 64'(d));
        @(negedge clk);
        bus.start = 1'b0; bus.md_D = 1'b0;
        check("mt_busy", 64'(bus.busy), 64'd0);
        e = exp_q.pop_front();
        check("mt_hilo", {bus.hi, bus.lo}, e);
        m_hi = e[63:32];
        m_lo = e[31:0];
    endtask

    initial begin
        reset = 1'b0;
        bus.start = 1'b1; bus.md_op = MD_MULT; bus.src_a = '0; bus.src_b = '0; bus.md_D = 1'b1;
        m_hi = '0; m_lo = '0;
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_stall", 64'(bus.stall_md), 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        bus.start = 1'b0; bus.md_D = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_op(MD_MULT,  32'hFFFFFFFE, 32'd3, 1'b0, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
        run_op(MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 5, 32'h00000001, 32'hFFFFFFFE, 1'b0);
        run_op(MD_DIV,   32'hFFFFFFF9, 32'd2, 1'b1, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op(MD_DIVU,  32'd7, 32'd0, 1'b0, ZDIV, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_mt(MD_MTHI, 32'h00001234, 1'b1);
        run_mt(MD_MTLO, 32'h00005678, 1'b0);
        run_op(MD_DIVU,  32'd100, 32'd7, 1'b0, 10, 32'd2, 32'd14, 1'b0);
        run_op(MD_DIV,   32'd7, 32'hFFFFFFFE, 1'b1, 10, 32'd1, 32'hFFFFFFFD, 1'b0);
        run_op(MD_DIV,   32'h80000000, 32'd0, 1'b0, ZDIV, 32'd1, 32'hFFFFFFFD, 1'b0);
        run_op(MD_MULT,  32'h12345678, 32'd0, 1'b0, ZMUL, 32'd0, 32'd0, 1'b0);
        run_op(MD_MULTU, 32'h00010000, 32'h00010000, 1'b1, 5, 32'd1, 32'd0, 1'b1);

        // Abort a MULT during its third busy cycle.
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = MD_MULT; bus.src_a = 32'd3; bus.src_b = 32'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_abort_busy", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        bus.start = 1'b1; bus.md_D = 1'b1;
        #1;
        check("abort_busy", 64'(bus.busy), 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        check("abort_stall", 64'(bus.stall_md), 64'd0);
        bus.start = 1'b0; bus.md_D = 1'b0;
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("post_abort_busy", 64'(bus.busy), 64'd0);
        check("post_abort_hilo", {bus.hi, bus.lo}, 64'd0);

        run_op(MD_MULTU, 32'd6, 32'd7, 1'b0, 5, 32'd0, 32'd42, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
